// File: rtl/ay_wb_sequencer_pkg.sv
// Shared types and constants for the AY PSG Wishbone write sequencer.
// No logic of its own; no latency.
// No flow control; pure definitions.
package ay_wb_sequencer_pkg;

    // Byte address of PSG chip 0; chip 1 sits one 16-bit word above it.
    localparam logic [16:0] AY_BASE_ADR_DFLT = 17'o177130;

    // Byte selects: the register latch cycle drives the full word, the data
    // cycle only the low byte.
    localparam logic [1:0] SEL_LATCH = 2'b11;
    localparam logic [1:0] SEL_DATA  = 2'b01;
    localparam logic [1:0] SEL_NONE  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_GAP,
        ST_DATA,
        ST_GAP2
    } seq_state_t;

    // One queued register write.
    typedef struct packed {
        logic       chip;
        logic [3:0] reg_idx;
        logic [7:0] dat;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Registered Wishbone initiator outputs.
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        wre;
        logic [1:0]  sel;
        logic [16:0] adr;
        logic [15:0] dat;
    } wb_out_t;

    // Byte address of the selected chip: chips are 2 bytes apart.
    function automatic logic [16:0] chip_adr(input logic [16:0] base, input logic chip);
        return base + {15'd0, chip, 1'b0};
    endfunction

endpackage

// File: rtl/ay_cmd_fifo.sv
// Small synchronous command FIFO with show-ahead read data.
// Latency: a push is visible on rd_vld/rd_dat one cycle after the write edge.
// Backpressure: wr_rdy drops when full; a pop is ignored while empty.
module ay_cmd_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic             pop;

    assign wr_rdy = (cnt_q != CNT_W'(DEPTH));
    assign rd_vld = (cnt_q != '0);
    assign push   = wr_vld & wr_rdy;
    assign pop    = rd_rdy & rd_vld;
    assign rd_dat = mem[rd_ptr_q];

    // Storage array; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_dat;
        end
    end

    // Pointers wrap naturally; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ay_wb_sequencer.sv
// Turns queued PSG register writes into Wishbone latch+data write cycles.
// Latency: stb rises two cycles after a command enters an empty, idle queue.
// Backpressure: cmd_ready_o low while the 4-entry queue is full; a bus cycle waits for ack or times out.
module ay_wb_sequencer
    import ay_wb_sequencer_pkg::*;
#(
    parameter logic [16:0] BASE_ADR = AY_BASE_ADR_DFLT,
    parameter int          TIMEOUT  = 15
) (
    input  logic        ppu_vm_clk_p,
    input  logic        ppu_vm_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_chip_i,
    input  logic [3:0]  cmd_reg_i,
    input  logic [7:0]  cmd_dat_i,
    output logic [16:0] ppu_wbm_adr_o,
    output logic [15:0] ppu_wbm_dat_o,
    output logic        ppu_wbm_cyc_o,
    output logic        ppu_wbm_stb_o,
    output logic        ppu_wbm_wre_o,
    output logic [1:0]  ppu_wbm_sel_o,
    input  logic        ppu_wbm_ack_i,
    input  logic [15:0] ppu_wbm_dat_i,
    output logic        busy_o,
    output logic        err_o,
    input  logic        err_clr_i
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    seq_state_t state_q;
    seq_state_t state_d;
    cmd_t       cmd_q;
    cmd_t       cmd_d;
    cmd_t       fifo_wr_dat;
    cmd_t       fifo_rd_dat;
    wb_out_t    bus_q;
    wb_out_t    bus_d;
    logic [7:0] tmo_q;
    logic [7:0] tmo_d;
    logic       tmo_hit;
    logic       err_q;
    logic       fifo_rd_vld;
    logic       fifo_rd_rdy;
    logic       unused_rd_dat;

    // Write-only initiator: read data from the responder is never looked at.
    assign unused_rd_dat = ^ppu_wbm_dat_i;

    assign fifo_wr_dat = '{chip: cmd_chip_i, reg_idx: cmd_reg_i, dat: cmd_dat_i};

    ay_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (4)
    ) u_cmd_fifo (
        .clk    (ppu_vm_clk_p),
        .rst_n  (ppu_vm_rst_n_i),
        .wr_vld (cmd_valid_i),
        .wr_rdy (cmd_ready_o),
        .wr_dat (fifo_wr_dat),
        .rd_vld (fifo_rd_vld),
        .rd_rdy (fifo_rd_rdy),
        .rd_dat (fifo_rd_dat)
    );

    // State register.
    always_ff @(posedge ppu_vm_clk_p or negedge ppu_vm_rst_n_i) begin
        if (!ppu_vm_rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, queue pop, timeout counting; a timeout skips straight to GAP2.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        tmo_d       = '0;
        tmo_hit     = 1'b0;
        fifo_rd_rdy = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP2: begin
                if (fifo_rd_vld) begin
                    fifo_rd_rdy = 1'b1;
                    cmd_d       = fifo_rd_dat;
                    state_d     = ST_LATCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LATCH, ST_DATA: begin
                if (ppu_wbm_ack_i) begin
                    state_d = (state_q == ST_LATCH) ? ST_GAP : ST_GAP2;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = ST_GAP2;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_GAP: begin
                state_d = ST_DATA;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus outputs for the upcoming state; idle and gap cycles drive all zeros.
    always_comb begin
        bus_d = '0;
        case (state_d)
            ST_LATCH: begin
                bus_d.cyc = 1'b1;
                bus_d.stb = 1'b1;
                bus_d.wre = 1'b1;
                bus_d.sel = SEL_LATCH;
                bus_d.adr = chip_adr(BASE_ADR, cmd_d.chip);
                bus_d.dat = {8'h00, 4'h0, cmd_d.reg_idx};
            end
            ST_DATA: begin
                bus_d.cyc = 1'b1;
                bus_d.stb = 1'b1;
                bus_d.wre = 1'b1;
                bus_d.sel = SEL_DATA;
                bus_d.adr = chip_adr(BASE_ADR, cmd_d.chip);
                bus_d.dat = {8'h00, cmd_d.dat};
            end
            default: begin
                bus_d.sel = SEL_NONE;
            end
        endcase
    end

    // Datapath registers: current command, registered bus, timeout count, sticky error.
    always_ff @(posedge ppu_vm_clk_p or negedge ppu_vm_rst_n_i) begin
        if (!ppu_vm_rst_n_i) begin
            cmd_q <= '0;
            bus_q <= '0;
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            cmd_q <= cmd_d;
            bus_q <= bus_d;
            tmo_q <= tmo_d;
            if (tmo_hit) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end
        end
    end

    assign ppu_wbm_cyc_o = bus_q.cyc;
    assign ppu_wbm_stb_o = bus_q.stb;
    assign ppu_wbm_wre_o = bus_q.wre;
    assign ppu_wbm_sel_o = bus_q.sel;
    assign ppu_wbm_adr_o = bus_q.adr;
    assign ppu_wbm_dat_o = bus_q.dat;
    assign err_o         = err_q;
    assign busy_o        = fifo_rd_vld | (state_q != ST_IDLE);

endmodule

// File: tb/tb_ay_wb_sequencer.sv
// Scoreboard bench for the AY Wishbone write sequencer.
// Expected bus beats are queued at command handshake and checked by a monitor.
// The responder model stalls ack by a programmable number of cycles.
module tb_ay_wb_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_chip = 1'b0;
    logic [3:0]  cmd_reg = 4'h0;
    logic [7:0]  cmd_dat = 8'h00;
    logic [16:0] adr;
    logic [15:0] dat;
    logic        cyc, stb, wre;
    logic [1:0]  sel;
    logic        ack = 1'b0;
    logic [15:0] rd_dat = 16'hDEAD;
    logic        busy, err;
    logic        err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [16:0] adr;
        logic [1:0]  sel;
        logic [15:0] dat;
    } beat_t;

    beat_t exp_q[$];
    bit    ack_en = 1'b1;
    int    ack_delay = 0;
    int    stall_cnt = 0;
    bit    gap_chk = 1'b0;

    always #5 clk = ~clk;

    ay_wb_sequencer #(
        .BASE_ADR (17'o177130),
        .TIMEOUT  (15)
    ) dut (
        .ppu_vm_clk_p   (clk),
        .ppu_vm_rst_n_i (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_chip_i     (cmd_chip),
        .cmd_reg_i      (cmd_reg),
        .cmd_dat_i      (cmd_dat),
        .ppu_wbm_adr_o  (adr),
        .ppu_wbm_dat_o  (dat),
        .ppu_wbm_cyc_o  (cyc),
        .ppu_wbm_stb_o  (stb),
        .ppu_wbm_wre_o  (wre),
        .ppu_wbm_sel_o  (sel),
        .ppu_wbm_ack_i  (ack),
        .ppu_wbm_dat_i  (rd_dat),
        .busy_o         (busy),
        .err_o          (err),
        .err_clr_i      (err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] exp_adr(input logic chip);
        return chip ? 17'o177132 : 17'o177130;
    endfunction

    // Called just after a negedge; returns at the negedge following the handshake edge.
    // nbeats: how many bus beats this command is expected to complete (0, 1 or 2).
    task automatic send(input logic chip, input logic [3:0] r, input logic [7:0] d, input int nbeats);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_chip  = chip;
        cmd_reg   = r;
        cmd_dat   = d;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready: got ready=0 after %0d cycles, expected 1", n);
            cmd_valid = 1'b0;
            return;
        end
        if (nbeats > 0) exp_q.push_back('{adr: exp_adr(chip), sel: 2'b11, dat: {12'h000, r}});
        if (nbeats > 1) exp_q.push_back('{adr: exp_adr(chip), sel: 2'b01, dat: {8'h00, d}});
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL %s: still busy=%0d pending=%0d, expected idle", name, busy, exp_q.size());
        end
    endtask

    // Responder: ack after ack_delay stalled strobe cycles.
    always @(negedge clk) begin
        if (cyc && stb && ack_en) begin
            if (stall_cnt >= ack_delay) begin
                ack = 1'b1;
                stall_cnt = 0;
            end else begin
                ack = 1'b0;
                stall_cnt++;
            end
        end else begin
            ack = 1'b0;
            stall_cnt = 0;
        end
    end

    // Monitor: every acknowledged beat is compared with the scoreboard head,
    // and the cycle after it must be a quiet gap.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #1;
            if (gap_chk) begin
                gap_chk = 1'b0;
                check("gap_quiet", 32'({cyc, stb, wre, sel}), 32'(0));
            end
            if (cyc && stb && ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got adr=%0o sel=%0b dat=%0h, expected none", adr, sel, dat);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_adr", 32'(adr), 32'(e.adr));
                    check("beat_sel", 32'(sel), 32'(e.sel));
                    check("beat_dat", 32'(dat), 32'(e.dat));
                    check("beat_wre", 32'(wre), 32'(1));
                end
                gap_chk = 1'b1;
            end
        end
    end

    logic       tbl_chip [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] tbl_reg  [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF};
    logic [7:0] tbl_dat  [10] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87, 8'h98, 8'hFF};

    initial begin
        int n;
        int run;
        bit saw_stb;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cyc", 32'(cyc), 32'(0));
        check("rst_stb", 32'(stb), 32'(0));
        check("rst_wre", 32'(wre), 32'(0));
        check("rst_sel", 32'(sel), 32'(0));
        check("rst_adr", 32'(adr), 32'(0));
        check("rst_dat", 32'(dat), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ready", 32'(cmd_ready), 32'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Single command, chip 0, immediate ack; stb rises two cycles after handshake
        send(1'b0, 4'h7, 8'h38, 2);
        cmd_valid = 1'b0;
        check("lat_first_cycle_stb", 32'(stb), 32'(0));
        @(negedge clk);
        check("lat_second_cycle_stb", 32'(stb), 32'(1));
        wait_idle("t1_idle");
        @(negedge clk);
        check("t1_busy_low", 32'(busy), 32'(0));

        // Chip 1 address
        send(1'b1, 4'hD, 8'h0E, 2);
        cmd_valid = 1'b0;
        wait_idle("t2_idle");

        // Five back-to-back commands with 3-cycle ack stall. The first one is
        // popped straight away, so the queue holds four after the fifth push.
        ack_delay = 3;
        for (int i = 0; i < 5; i++) begin
            send(tbl_chip[i], tbl_reg[i], tbl_dat[i], 2);
        end
        check("full_ready_low", 32'(cmd_ready), 32'(0));
        cmd_valid = 1'b0;
        wait_idle("t3_idle");
        check("t3_ready_back", 32'(cmd_ready), 32'(1));

        // No ack: stb held exactly 15 cycles, error set, no data cycle
        ack_en = 1'b0;
        send(1'b0, 4'h2, 8'hAA, 0);
        cmd_valid = 1'b0;
        n = 0;
        while (!stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        run = 0;
        while (stb && run < 100) begin
            run++;
            @(negedge clk);
        end
        check("tmo_stb_cycles", 32'(run), 32'(15));
        check("tmo_err_set", 32'(err), 32'(1));
        saw_stb = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (stb) saw_stb = 1'b1;
        end
        check("tmo_no_data_cycle", 32'(saw_stb), 32'(0));
        check("tmo_busy_low", 32'(busy), 32'(0));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", 32'(err), 32'(0));

        // Clear held high across a new timeout: the timeout wins
        err_clr = 1'b1;
        send(1'b1, 4'h1, 8'h11, 0);
        cmd_valid = 1'b0;
        n = 0;
        while (!stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        run = 0;
        while (stb && run < 100) begin
            run++;
            @(negedge clk);
        end
        check("tmo2_stb_cycles", 32'(run), 32'(15));
        check("err_set_wins_clr", 32'(err), 32'(1));
        err_clr = 1'b0;
        @(negedge clk);
        check("err_sticky", 32'(err), 32'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared2", 32'(err), 32'(0));
        ack_en = 1'b1;

        // Reset during DATA with stb high; a second queued command is lost too
        ack_delay = 5;
        send(1'b0, 4'h3, 8'h55, 1);
        send(1'b1, 4'h4, 8'h66, 0);
        cmd_valid = 1'b0;
        n = 0;
        while (!(stb && sel == 2'b01) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_in_data", 32'({stb, sel}), 32'(3'b101));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cyc", 32'(cyc), 32'(0));
        check("async_rst_stb", 32'(stb), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'(1));
        check("post_rst_busy", 32'(busy), 32'(0));
        repeat (5) @(negedge clk);
        check("post_rst_quiet", 32'({cyc, stb}), 32'(0));

        // Ten commands with random valid gaps; order and count checked by the monitor
        ack_delay = 1;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(tbl_chip[i], tbl_reg[i], tbl_dat[i], 2);
        end
        cmd_valid = 1'b0;
        wait_idle("t7_idle");
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        check("final_err", 32'(err), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
